// File: rtl/axis_packet_arbiter_if.sv
// ---------------------------------------------------------------------------
// axis_packet_arbiter_if
//
// Bundles the stream signals of the packet arbiter: NUM_SRC slave streams
// flowing into the arbiter and one shared master stream flowing out of it.
//
// Signals:
//   S_AXIS_TVALID [NUM_SRC]      per-source valid
//   S_AXIS_TDATA  [NUM_SRC*W]    source i occupies bits [i*W +: W]
//   S_AXIS_TLAST  [NUM_SRC]      per-source last
//   S_AXIS_TREADY [NUM_SRC]      per-source ready
//   M_AXIS_TVALID / TDATA / TSTRB / TLAST / TREADY   shared output stream
//
// Modports:
//   master : the arbiter's view (drives M_AXIS_* and S_AXIS_TREADY)
//   slave  : the environment's view (sources and downstream sink)
// ---------------------------------------------------------------------------
interface axis_packet_arbiter_if #(
    parameter int NUM_SRC              = 4,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
);
    logic [NUM_SRC-1:0]                      S_AXIS_TVALID;
    logic [NUM_SRC*C_M_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA;
    logic [NUM_SRC-1:0]                      S_AXIS_TLAST;
    logic [NUM_SRC-1:0]                      S_AXIS_TREADY;

    logic                                    M_AXIS_TVALID;
    logic [C_M_AXIS_TDATA_WIDTH-1:0]         M_AXIS_TDATA;
    logic [C_M_AXIS_TDATA_WIDTH/8-1:0]       M_AXIS_TSTRB;
    logic                                    M_AXIS_TLAST;
    logic                                    M_AXIS_TREADY;

    modport master (
        input  S_AXIS_TVALID,
        input  S_AXIS_TDATA,
        input  S_AXIS_TLAST,
        output S_AXIS_TREADY,
        output M_AXIS_TVALID,
        output M_AXIS_TDATA,
        output M_AXIS_TSTRB,
        output M_AXIS_TLAST,
        input  M_AXIS_TREADY
    );

    modport slave (
        output S_AXIS_TVALID,
        output S_AXIS_TDATA,
        output S_AXIS_TLAST,
        input  S_AXIS_TREADY,
        input  M_AXIS_TVALID,
        input  M_AXIS_TDATA,
        input  M_AXIS_TSTRB,
        input  M_AXIS_TLAST,
        output M_AXIS_TREADY
    );
endinterface

// File: rtl/axis_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_packet_arbiter
//
// Packet-level round-robin arbiter sharing one AXI-Stream master among
// NUM_SRC sources. A grant is held from the first beat of a packet up to and
// including its TLAST, so packets never interleave. The shared output is a
// single registered stage. Packets longer than MAX_PKT_WORDS are cut: the
// MAX_PKT_WORDS-th beat goes out with TLAST forced, the rest of the source
// packet is swallowed, and the sticky OVERRUN flag is raised.
//
// Ports:
//   M_AXIS_ACLK    in   clock, rising edge
//   M_AXIS_ARESET  in   synchronous active-high reset
//   axis           if   stream bundle (master modport), see the interface
//   GRANT          out  index of the current or most recent owner
//   BUSY           out  high whenever the arbiter is not idle
//   OVERRUN        out  sticky, set when any packet is truncated
// ---------------------------------------------------------------------------
module axis_packet_arbiter #(
    parameter  int NUM_SRC              = 4,
    parameter  int C_M_AXIS_TDATA_WIDTH = 32,
    parameter  int MAX_PKT_WORDS        = 8,
    localparam int IDX_W                = $clog2(NUM_SRC)
) (
    input  logic                  M_AXIS_ACLK,
    input  logic                  M_AXIS_ARESET,
    axis_packet_arbiter_if.master axis,
    output logic [IDX_W-1:0]      GRANT,
    output logic                  BUSY,
    output logic                  OVERRUN
);

    localparam int W     = C_M_AXIS_TDATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_PKT_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   beat_cnt_q;
    logic               busy_q;
    logic               overrun_q;

    logic               m_valid_q;
    logic [W-1:0]       m_data_q;
    logic               m_last_q;

    logic               load_ok;
    logic               src_valid;
    logic               src_last;
    logic [W-1:0]       src_data;
    logic [NUM_SRC-1:0] s_ready;
    logic               pass_accept;
    logic               drop_accept;
    logic               at_limit;
    logic [IDX_W-1:0]   rr_next_d;

    // First requester at or after ptr, searching upward with wrap. Only
    // called when at least one request is present.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] sel;
        logic [IDX_W-1:0] cand;
        logic             found;
        int               idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx  = (int'(ptr) + k) % NUM_SRC;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // The output register may take a new beat when empty or draining now.
    assign load_ok = !m_valid_q || axis.M_AXIS_TREADY;

    // Route the granted source. TREADY depends only on state, grant and the
    // downstream ready, never on the source's own TVALID.
    always_comb begin
        src_valid = 1'b0;
        src_last  = 1'b0;
        src_data  = '0;
        s_ready   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == IDX_W'(i)) begin
                src_valid  = axis.S_AXIS_TVALID[i];
                src_last   = axis.S_AXIS_TLAST[i];
                src_data   = axis.S_AXIS_TDATA[i*W +: W];
                s_ready[i] = (state_q == ST_PASS) ? load_ok : (state_q == ST_DROP);
            end
        end
    end

    assign pass_accept = (state_q == ST_PASS) && src_valid && load_ok;
    assign drop_accept = (state_q == ST_DROP) && src_valid;
    assign at_limit    = (beat_cnt_q == CNT_W'(MAX_PKT_WORDS - 1));

    // Explicit wrap so non-power-of-two NUM_SRC stays in range.
    assign rr_next_d = (grant_q == IDX_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            // Drain; a beat loaded below in the same cycle keeps TVALID high.
            if (axis.M_AXIS_TREADY) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (|axis.S_AXIS_TVALID) begin
                        grant_q    <= rr_pick(axis.S_AXIS_TVALID, rr_ptr_q);
                        beat_cnt_q <= '0;
                        state_q    <= ST_PASS;
                        busy_q     <= 1'b1;
                    end
                end

                ST_PASS: begin
                    if (pass_accept) begin
                        // ---- output register stage ----
                        m_valid_q  <= 1'b1;
                        m_data_q   <= src_data;
                        m_last_q   <= src_last || at_limit;
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (src_last) begin
                            rr_ptr_q <= rr_next_d;
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                        end else if (at_limit) begin
                            // Packet truncated: swallow its tail in DROP.
                            overrun_q <= 1'b1;
                            rr_ptr_q  <= rr_next_d;
                            state_q   <= ST_DROP;
                        end
                    end
                end

                ST_DROP: begin
                    if (drop_accept && src_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign axis.S_AXIS_TREADY = s_ready;
    assign axis.M_AXIS_TVALID = m_valid_q;
    assign axis.M_AXIS_TDATA  = m_data_q;
    assign axis.M_AXIS_TLAST  = m_last_q;
    assign axis.M_AXIS_TSTRB  = '1;

    assign GRANT   = grant_q;
    assign BUSY    = busy_q;
    assign OVERRUN = overrun_q;

endmodule
